// File: rtl/digit_scan_counter.sv
// digit_scan_counter: debounced BCD event counter with time-multiplexed digit scan.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading-zero digit slots).
`default_nettype none

module digit_scan_counter #(
    parameter int NUM_DIGITS      = 4,
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_up,
    input  logic                  btn_clr,
    input  logic                  count_en,
    output logic [3:0]            digit_code,
    output logic [NUM_DIGITS-1:0] digit_sel_n,
    output logic                  wrap
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    // Button index 0 is btn_up, index 1 is btn_clr.
    logic [1:0]            sync1_q, sync2_q, acc_q;
    logic [DB_W-1:0]       db_cnt_q [2];
    logic                  up_prev_q;
    logic                  inc;

    logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
    logic                  wrap_q, wrap_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [3:0]            code_q, code_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            acc_q     <= '0;
            up_prev_q <= 1'b0;
            for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
        end else begin
            sync1_q   <= {btn_clr, btn_up};
            sync2_q   <= sync1_q;
            up_prev_q <= acc_q[0];
            // Counter runs only while the sample disagrees with the accepted level.
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] == acc_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt_q[b] <= '0;
                    acc_q[b]    <= sync2_q[b];
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign inc = acc_q[0] & ~up_prev_q;

    always_comb begin
        logic carry;
        digits_d = digits_q;
        wrap_d   = 1'b0;
        carry    = 1'b0;
        if (acc_q[1]) begin
            digits_d = '0;
        end else if (inc && count_en) begin
            carry = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (carry) begin
                    if (digits_q[i] == 4'd9) begin
                        digits_d[i] = 4'd0;
                    end else begin
                        digits_d[i] = digits_q[i] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end
    end

    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        code_d = digits_q[idx_d];
        sel_d  = ~(SEL_ONE << idx_d);
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic blank;
            blank = (idx_d != '0);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if ((i >= int'(idx_d)) && (digits_q[i] != 4'd0)) blank = 1'b0;
            end
            if (blank) sel_d = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            wrap_q   <= 1'b0;
            pre_q    <= '0;
            idx_q    <= '0;
            code_q   <= 4'd0;
            sel_q    <= ~SEL_ONE;
        end else begin
            digits_q <= digits_d;
            wrap_q   <= wrap_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            code_q   <= code_d;
            sel_q    <= sel_d;
        end
    end

    assign digit_code  = code_q;
    assign digit_sel_n = sel_q;
    assign wrap        = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_digit_scan_counter.sv
// tb_digit_scan_counter: directed self-checking bench for digit_scan_counter.
`default_nettype none

module tb_digit_scan_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up1 = 1'b0, clr1 = 1'b0, en1 = 1'b1;
    logic [3:0] code1, sel1;
    logic       wrap1;
    logic       up2 = 1'b0, clr2 = 1'b0, en2 = 1'b1;
    logic [3:0] code2;
    logic [1:0] sel2;
    logic       wrap2;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    digit_scan_counter #(.NUM_DIGITS(4), .SCAN_DIV(3), .DEBOUNCE_CYCLES(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_up(up1), .btn_clr(clr1), .count_en(en1),
        .digit_code(code1), .digit_sel_n(sel1), .wrap(wrap1)
    );

    digit_scan_counter #(.NUM_DIGITS(2), .SCAN_DIV(2), .DEBOUNCE_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .btn_up(up2), .btn_clr(clr2), .count_en(en2),
        .digit_code(code2), .digit_sel_n(sel2), .wrap(wrap2)
    );

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    task automatic press1(input int hold);
        @(negedge clk) up1 = 1'b1;
        repeat (hold) @(negedge clk);
        up1 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic press2();
        @(negedge clk) up2 = 1'b1;
        repeat (6) @(negedge clk);
        up2 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic read1(output logic [15:0] v);
        logic [3:0] oh;
        v = '0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                oh = 4'b0001 << i;
                if (sel1 === ~oh) v[i*4 +: 4] = code1;
            end
        end
    endtask

    task automatic read2(output logic [7:0] v);
        v = '0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (sel2 === 2'b10) v[3:0] = code2;
            if (sel2 === 2'b01) v[7:4] = code2;
        end
    endtask

    task automatic check_count1(input string name, input logic [15:0] exp);
        logic [15:0] v;
        read1(v);
        chk_cnt++;
        if (v !== exp) $display("FAIL %s: count got %h expected %h", name, v, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        exp = BLANK ? 4'b1111 : 4'b1101;
        chk_cnt++;
        if (sel1 !== exp) $display("FAIL pre_reset_slot: sel %b expected %b", sel1, exp);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (code1 !== 4'd0 || sel1 !== 4'b1110 || wrap1 !== 1'b0)
            $display("FAIL async_reset: code %h sel %b wrap %b expected 0 1110 0", code1, sel1, wrap1);
        else pass_cnt++;
        chk_cnt++;
        if (sel2 !== 2'b10) $display("FAIL async_reset2: sel %b expected 10", sel2);
        else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c < 3) exp = 4'b1110;
            else if (BLANK) exp = 4'b1111;
            else exp = (c < 6) ? 4'b1101 : 4'b1011;
            chk_cnt++;
            if (sel1 !== exp) $display("FAIL scan_after_reset c%0d: sel %b expected %b", c, sel1, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_debounce();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk) up1 = 1'b1;
            repeat (k) @(negedge clk);
            up1 = 1'b0;
            repeat (8) @(negedge clk);
        end
        check_count1("glitch_rejected", 16'h0000);
        @(negedge clk) up1 = 1'b1;
        repeat (20) @(negedge clk);
        check_count1("held_press", 16'h0001);
        repeat (80) @(negedge clk);
        up1 = 1'b0;
        repeat (8) @(negedge clk);
        check_count1("released_press", 16'h0001);
    endtask

    task automatic test_scan();
        logic [3:0] prev, exp_sel, exp_code;
        bit found;
        for (int p = 0; p < 6; p++) press1(8);
        check_count1("count_0007", 16'h0007);
        found = 1'b0;
        prev  = sel1;
        for (int t = 0; t < 30 && !found; t++) begin
            @(negedge clk);
            if (sel1 === 4'b1110 && prev !== 4'b1110) found = 1'b1;
            prev = sel1;
        end
        chk_cnt++;
        if (!found) $display("FAIL scan_align: sel %b never entered slot 0", sel1);
        else pass_cnt++;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            exp_code = (c < 3) ? 4'd7 : 4'd0;
            if (c < 3) exp_sel = 4'b1110;
            else if (BLANK) exp_sel = 4'b1111;
            else exp_sel = ~(4'b0001 << (c / 3));
            chk_cnt++;
            if (sel1 !== exp_sel || code1 !== exp_code)
                $display("FAIL scan_c%0d: sel %b code %h expected %b %h", c, sel1, code1, exp_sel, exp_code);
            else pass_cnt++;
        end
    endtask

    task automatic test_clear();
        bit wrap_seen;
        for (int p = 0; p < 35; p++) press1(8);
        check_count1("count_0042", 16'h0042);
        wrap_seen = 1'b0;
        @(negedge clk) begin up1 = 1'b1; clr1 = 1'b1; end
        repeat (10) begin @(negedge clk); if (wrap1) wrap_seen = 1'b1; end
        up1 = 1'b0; clr1 = 1'b0;
        repeat (8) @(negedge clk);
        check_count1("clear_priority", 16'h0000);
        chk_cnt++;
        if (wrap_seen) $display("FAIL clear_wrap: wrap 1 expected 0");
        else pass_cnt++;
        press1(8);
        check_count1("after_clear", 16'h0001);
    endtask

    task automatic test_carry();
        bit ok;
        for (int p = 0; p < 1098; p++) press1(8);
        check_count1("count_1099", 16'h1099);
        press1(8);
        check_count1("carry_1100", 16'h1100);
        for (int d = 1; d <= 2; d++) begin
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                @(negedge clk);
                if (sel1 === ~(4'b0001 << d)) ok = 1'b1;
            end
            chk_cnt++;
            if (!ok || code1 !== d - 1)
                $display("FAIL digit%0d_slot: code %h found %0d expected %0d", d, code1, ok, d - 1);
            else pass_cnt++;
        end
        en1 = 1'b0;
        press1(8);
        en1 = 1'b1;
        check_count1("count_en_low", 16'h1100);
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        bit wrap_seen;
        for (int p = 0; p < 99; p++) press2();
        read2(v);
        chk_cnt++;
        if (v !== 8'h99) $display("FAIL count2_99: got %h expected 99", v);
        else pass_cnt++;
        @(negedge clk) up2 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk_cnt++;
            if (wrap2 !== (k == 5)) $display("FAIL wrap_c%0d: wrap %b expected %b", k, wrap2, (k == 5));
            else pass_cnt++;
        end
        up2 = 1'b0;
        repeat (6) @(negedge clk);
        read2(v);
        chk_cnt++;
        if (v !== 8'h00) $display("FAIL count2_wrapped: got %h expected 00", v);
        else pass_cnt++;
        for (int p = 0; p < 99; p++) press2();
        en2 = 1'b0;
        wrap_seen = 1'b0;
        @(negedge clk) up2 = 1'b1;
        repeat (8) begin @(negedge clk); if (wrap2) wrap_seen = 1'b1; end
        up2 = 1'b0;
        repeat (6) @(negedge clk);
        en2 = 1'b1;
        chk_cnt++;
        if (wrap_seen) $display("FAIL wrap_disabled: wrap 1 expected 0");
        else pass_cnt++;
        read2(v);
        chk_cnt++;
        if (v !== 8'h99) $display("FAIL count2_disabled: got %h expected 99", v);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_scan();
        test_clear();
        test_carry();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
